// File: rtl/sd_debounce.sv
// Synchroniser plus hold-time filter for a bouncy asynchronous pin (card-detect, write-protect).
// Define SD_DEBOUNCE_STATUS_EN to add the sticky "changed" flag with its clr input.
module sd_debounce #(
    parameter int   SYNC_STAGES = 2,
    parameter int   CNT_W       = 16,
    parameter logic INIT_VAL    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             raw,
    input  logic [CNT_W-1:0] hold_time,
`ifdef SD_DEBOUNCE_STATUS_EN
    input  logic             clr,
    output logic             changed,
`endif
    output logic             sig,
    output logic             busy
);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_WAIT   = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       hold_q, hold_d;
    logic                   sig_q, sig_d;

    // raw lands straight on the first flop so the chain can resolve metastability.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {SYNC_STAGES{INIT_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            sig_q   <= INIT_VAL;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            sig_q   <= sig_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        sig_d   = sig_q;
        unique case (state_q)
            ST_STABLE: begin
                if (s != sig_q) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                    hold_d  = hold_time;
                end
            end
            ST_WAIT: begin
                if (s == sig_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == hold_q) begin
                    // cnt stops at hold_q, so an all-ones hold time never wraps.
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                    sig_d   = s;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_STABLE;
            end
        endcase
    end

    assign sig  = sig_q;
    assign busy = (state_q == ST_WAIT);

`ifdef SD_DEBOUNCE_STATUS_EN
    logic sig_dly_q;
    logic changed_q;

    // Flag rises the cycle after sig moves; a coincident clr loses to the set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig_dly_q <= INIT_VAL;
            changed_q <= 1'b0;
        end else begin
            sig_dly_q <= sig_q;
            if (sig_q != sig_dly_q) begin
                changed_q <= 1'b1;
            end else if (clr) begin
                changed_q <= 1'b0;
            end
        end
    end

    assign changed = changed_q;
`else
    // Status flag not built.
`endif

endmodule

// File: tb/tb_sd_debounce.sv
// Directed bench for sd_debounce: reset, clean steps, bounce, zero/all-ones hold, mid-WAIT changes.
// Inputs change and outputs are sampled on the falling edge; "after edge E0+i" is loop index i.
module tb_sd_debounce;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             raw;
    logic [CNT_W-1:0] hold_time;
    logic             sig;
    logic             busy;
`ifdef SD_DEBOUNCE_STATUS_EN
    logic             clr;
    logic             changed;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    sd_debounce #(
        .SYNC_STAGES (2),
        .CNT_W       (CNT_W),
        .INIT_VAL    (1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .raw       (raw),
        .hold_time (hold_time),
`ifdef SD_DEBOUNCE_STATUS_EN
        .clr       (clr),
        .changed   (changed),
`endif
        .sig       (sig),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        rst       = 1'b0;
        raw       = 1'b0;
        hold_time = 16'd5;
`ifdef SD_DEBOUNCE_STATUS_EN
        clr       = 1'b0;
`endif
        #1;
        check("rst_sig_async", 32'(sig), 32'd0);
        check("rst_busy_async", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("rst_sig", 32'(sig), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_sig", 32'(sig), 32'd0);

        // Clean rising step, H=5: WAIT after E0+2..E0+7, sig high from E0+8.
        raw = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            check($sformatf("step_sig_%0d", i), 32'(sig), 32'(i >= 8));
            check($sformatf("step_busy_%0d", i), 32'(busy), 32'(i >= 2 && i <= 7));
        end

        // Zero hold, falling: one WAIT cycle, sig low from E0+3.
        hold_time = 16'd0;
        raw = 1'b0;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("zero_sig_%0d", i), 32'(sig), 32'(i < 3));
            check($sformatf("zero_busy_%0d", i), 32'(busy), 32'(i == 2));
        end

        // Bounce: high 4, low 2, then steady high (final rise at E0+6, sig at E0+14).
        hold_time = 16'd5;
        for (int i = 0; i <= 15; i++) begin
            raw = (i < 4 || i >= 6);
            @(negedge clk);
            check($sformatf("bounce_sig_%0d", i), 32'(sig), 32'(i >= 14));
            check($sformatf("bounce_busy_%0d", i), 32'(busy),
                  32'((i >= 2 && i <= 5) || (i >= 8 && i <= 13)));
        end

        // Reset mid-WAIT: sig=1 qualifying a fall, then async reset.
        raw = 1'b0;
        repeat (4) @(negedge clk);
        check("prerst_busy", 32'(busy), 32'd1);
        check("prerst_sig", 32'(sig), 32'd1);
        #2;
        rst = 1'b0;
        raw = 1'b1;
        #1;
        check("midrst_sig", 32'(sig), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            check($sformatf("postrst_sig_%0d", i), 32'(sig), 32'(i >= 8));
            check($sformatf("postrst_busy_%0d", i), 32'(busy), 32'(i >= 2 && i <= 7));
        end

        // hold_time rewritten 3 cycles into WAIT: original H=10 still governs (fall at E0+13).
        hold_time = 16'd10;
        raw = 1'b0;
        for (int i = 0; i <= 14; i++) begin
            if (i == 5) hold_time = 16'd2;
            @(negedge clk);
            check($sformatf("hchg_sig_%0d", i), 32'(sig), 32'(i < 13));
            check($sformatf("hchg_busy_%0d", i), 32'(busy), 32'(i >= 2 && i <= 12));
        end

        // All-ones hold: counter must run to 65535 without wrapping; rise at E0+65538.
        hold_time = 16'hFFFF;
        raw = 1'b1;
        for (int i = 0; i <= 65538; i++) begin
            @(negedge clk);
            if (i == 3 || i == 65537) begin
                check($sformatf("max_sig_%0d", i), 32'(sig), 32'd0);
                check($sformatf("max_busy_%0d", i), 32'(busy), 32'd1);
            end
            if (i == 65538) begin
                check("max_sig_end", 32'(sig), 32'd1);
                check("max_busy_end", 32'(busy), 32'd0);
            end
        end

`ifdef SD_DEBOUNCE_STATUS_EN
        check("chg_sticky", 32'(changed), 32'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("chg_clr", 32'(changed), 32'd0);
        // Fall with H=0: sig toggles at E0+3, flag sets at E0+4 while clr is also high.
        hold_time = 16'd0;
        raw = 1'b0;
        for (int i = 0; i <= 5; i++) begin
            clr = (i == 4);
            @(negedge clk);
            check($sformatf("chg_set_%0d", i), 32'(changed), 32'(i >= 4));
        end
        clr = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
